// File: rtl/lcd_write_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_write_arbiter_if                                         |
// | Description : Request/ack handshake and LCD payload bundle for the arbiter. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface lcd_write_arbiter_if;
  logic        req0;
  logic [25:0] pc0;
  logic [5:0]  opcode0;
  logic [31:0] data0;
  logic        req1;
  logic [25:0] pc1;
  logic [5:0]  opcode1;
  logic [31:0] data1;
  logic        ack0;
  logic        ack1;
  logic        o_wlcd;
  logic [25:0] o_pc;
  logic [5:0]  o_opcode;
  logic [31:0] o_data;
  logic        o_src;
  logic        busy;

  // Requester/observer side
  modport master (
    output req0, pc0, opcode0, data0,
    output req1, pc1, opcode1, data1,
    input  ack0, ack1, o_wlcd, o_pc, o_opcode, o_data, o_src, busy
  );

  // Arbiter side
  modport slave (
    input  req0, pc0, opcode0, data0,
    input  req1, pc1, opcode1, data1,
    output ack0, ack1, o_wlcd, o_pc, o_opcode, o_data, o_src, busy
  );
endinterface
`default_nettype wire

// File: rtl/lcd_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_write_arbiter                                            |
// | Description : Two-requester arbiter for the LCD update port; strobes then   |
// |               dwells on each granted message. LCD_ARB_FIXED_PRIO_EN selects |
// |               fixed priority (requester 0) instead of round-robin.          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module lcd_write_arbiter #(
  parameter int STROBE_CYCLES = 4,
  parameter int DWELL_CYCLES  = 25_000_000
) (
  input wire logic           iCLK_50MHZ,
  input wire logic           iRST_N,
  lcd_write_arbiter_if.slave bus
);

  localparam int c_MAX_LOAD = (STROBE_CYCLES > DWELL_CYCLES) ? (STROBE_CYCLES - 1)
                                                             : (DWELL_CYCLES - 1);
  localparam int c_CNT_W    = (c_MAX_LOAD < 1) ? 1 : $clog2(c_MAX_LOAD + 1);

  localparam logic [c_CNT_W-1:0] c_STROBE_LOAD = c_CNT_W'(STROBE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_DWELL_LOAD  = c_CNT_W'(DWELL_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_DWELL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_ack0;
  logic                r_ack1;
  logic                r_wlcd;
  logic [25:0]         r_pc;
  logic [5:0]          r_opcode;
  logic [31:0]         r_data;
  logic                r_src;
  logic                r_busy;

  logic                w_any_req;
  logic                w_win1;

  assign w_any_req = bus.req0 | bus.req1;

`ifdef LCD_ARB_FIXED_PRIO_EN
  assign w_win1 = bus.req1 & ~bus.req0;
`else
  // Last-granted requester loses a tie; resets to 1 so requester 0 wins first.
  logic r_last;

  assign w_win1 = bus.req1 & (~bus.req0 | ~r_last);

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last <= w_win1;
    end
  end
`endif

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_wlcd   <= 1'b0;
      r_pc     <= '0;
      r_opcode <= '0;
      r_data   <= '0;
      r_src    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_ack0   <= ~w_win1;
            r_ack1   <= w_win1;
            r_pc     <= w_win1 ? bus.pc1     : bus.pc0;
            r_opcode <= w_win1 ? bus.opcode1 : bus.opcode0;
            r_data   <= w_win1 ? bus.data1   : bus.data0;
            r_src    <= w_win1;
            r_wlcd   <= 1'b1;
            r_busy   <= 1'b1;
            r_cnt    <= c_STROBE_LOAD;
            r_state  <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (r_cnt == '0) begin
            r_wlcd  <= 1'b0;
            r_cnt   <= c_DWELL_LOAD;
            r_state <= S_DWELL;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        S_DWELL: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        default: begin
          r_wlcd  <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.o_wlcd   = r_wlcd;
  assign bus.o_pc     = r_pc;
  assign bus.o_opcode = r_opcode;
  assign bus.o_data   = r_data;
  assign bus.o_src    = r_src;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lcd_write_arbiter                                         |
// | Description : Directed self-checking bench, STROBE_CYCLES=4 DWELL_CYCLES=10.|
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_lcd_write_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  lcd_write_arbiter_if bus ();

  lcd_write_arbiter #(
    .STROBE_CYCLES (4),
    .DWELL_CYCLES  (10)
  ) dut (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.req0 = 1'b0; bus.pc0 = '0; bus.opcode0 = '0; bus.data0 = '0;
    bus.req1 = 1'b0; bus.pc1 = '0; bus.opcode1 = '0; bus.data1 = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && bus.busy !== 1'b0; i++) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL wait_idle: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0 = 1'b1; bus.pc0 = 26'h1234567; bus.opcode0 = 6'h15; bus.data0 = 32'h01020304;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.ack0, bus.ack1, bus.o_wlcd, bus.o_src, bus.busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: ack0/ack1/wlcd/src/busy=%b required 00000",
               {bus.ack0, bus.ack1, bus.o_wlcd, bus.o_src, bus.busy});
    end
    n_vec++;
    if ({bus.o_pc, bus.o_opcode, bus.o_data} !== 64'b0) begin
      n_err++;
      $display("FAIL reset_payload: %h required 0", {bus.o_pc, bus.o_opcode, bus.o_data});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.ack0 !== 1'b1) begin
      n_err++; $display("FAIL release_ack0: %b required 1", bus.ack0);
    end
    n_vec++;
    if (bus.o_wlcd !== 1'b1) begin
      n_err++; $display("FAIL release_wlcd: %b required 1", bus.o_wlcd);
    end
    n_vec++;
    if (bus.o_pc !== 26'h1234567) begin
      n_err++; $display("FAIL release_pc: %h required 1234567", bus.o_pc);
    end
    bus.req0 = 1'b0;
    wait_idle();
  endtask

  task automatic test_single();
    int n_ack0 = 0, n_ack1 = 0, n_wlcd = 0, n_busy = 0, n_bad = 0, first_ack = -1;
    @(negedge clk);
    clear_inputs();
    bus.req0 = 1'b1; bus.pc0 = 26'h0000ABC; bus.opcode0 = 6'h3F; bus.data0 = 32'hDEADBEEF;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.ack0 === 1'b1) begin
        n_ack0++;
        if (first_ack < 0) first_ack = i;
        bus.req0 = 1'b0;
      end
      if (bus.ack1 === 1'b1) n_ack1++;
      if (bus.o_wlcd === 1'b1) n_wlcd++;
      if (bus.busy === 1'b1) n_busy++;
      if ({bus.o_pc, bus.o_opcode, bus.o_data, bus.o_src} !== {26'h0000ABC, 6'h3F, 32'hDEADBEEF, 1'b0})
        n_bad++;
    end
    n_vec++;
    if (n_ack0 !== 1 || n_ack1 !== 0) begin
      n_err++; $display("FAIL single_acks: ack0=%0d ack1=%0d required 1/0", n_ack0, n_ack1);
    end
    n_vec++;
    if (first_ack !== 1) begin
      n_err++; $display("FAIL single_latency: cycle %0d required 1", first_ack);
    end
    n_vec++;
    if (n_wlcd !== 4) begin
      n_err++; $display("FAIL single_wlcd_len: %0d required 4", n_wlcd);
    end
    n_vec++;
    if (n_busy !== 14) begin
      n_err++; $display("FAIL single_busy_len: %0d required 14", n_busy);
    end
    n_vec++;
    if (n_bad !== 0) begin
      n_err++; $display("FAIL single_payload_hold: %0d bad cycles required 0", n_bad);
    end
  endtask

  task automatic test_round_robin();
    int g_cyc[4];
    int g_src[4];
    int ng = 0;
    logic drop0 = 1'b0, drop1 = 1'b0;
    apply_reset();
    @(negedge clk);
    bus.req0 = 1'b1; bus.pc0 = 26'h0AAAAAA; bus.opcode0 = 6'h0A; bus.data0 = 32'hAAAA0000;
    bus.req1 = 1'b1; bus.pc1 = 26'h1555555; bus.opcode1 = 6'h35; bus.data1 = 32'h5555FFFF;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (drop0) begin bus.req0 = 1'b1; drop0 = 1'b0; end
      if (drop1) begin bus.req1 = 1'b1; drop1 = 1'b0; end
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
        n_vec++;
        if (bus.o_src !== bus.ack1 || bus.ack0 === bus.ack1) begin
          n_err++;
          $display("FAIL rr_src: src=%b ack0=%b ack1=%b", bus.o_src, bus.ack0, bus.ack1);
        end
        n_vec++;
        if (bus.o_data !== (bus.ack1 ? 32'h5555FFFF : 32'hAAAA0000)) begin
          n_err++; $display("FAIL rr_data: %h for ack1=%b", bus.o_data, bus.ack1);
        end
        if (ng < 4) begin
          g_cyc[ng] = i;
          g_src[ng] = bus.ack1 ? 1 : 0;
        end
        ng++;
        if (bus.ack0 === 1'b1) begin bus.req0 = 1'b0; drop0 = 1'b1; end
        if (bus.ack1 === 1'b1) begin bus.req1 = 1'b0; drop1 = 1'b1; end
      end
    end
    n_vec++;
    if (ng !== 4) begin
      n_err++; $display("FAIL rr_grant_count: %0d required 4", ng);
    end
    for (int k = 0; k < 4 && k < ng; k++) begin
      n_vec++;
      if (g_src[k] !== (k % 2) || g_cyc[k] !== 1 + 15 * k) begin
        n_err++;
        $display("FAIL rr_grant%0d: src=%0d cycle=%0d required src=%0d cycle=%0d",
                 k, g_src[k], g_cyc[k], k % 2, 1 + 15 * k);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle();
  endtask

`ifdef LCD_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int n_a0 = 0, n_a1 = 0, late = -1;
    logic drop0 = 1'b0;
    apply_reset();
    @(negedge clk);
    bus.req0 = 1'b1; bus.pc0 = 26'h0000111; bus.data0 = 32'h11111111;
    bus.req1 = 1'b1; bus.pc1 = 26'h0000222; bus.data1 = 32'h22222222;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (drop0) begin bus.req0 = 1'b1; drop0 = 1'b0; end
      if (bus.ack1 === 1'b1) n_a1++;
      if (bus.ack0 === 1'b1) begin n_a0++; bus.req0 = 1'b0; drop0 = 1'b1; end
    end
    n_vec++;
    if (n_a1 !== 0 || n_a0 !== 4) begin
      n_err++; $display("FAIL fixed_tie: ack0=%0d ack1=%0d required 4/0", n_a0, n_a1);
    end
    bus.req0 = 1'b0;
    for (int j = 1; j <= 30 && late < 0; j++) begin
      @(negedge clk);
      if (bus.ack1 === 1'b1) late = j;
    end
    n_vec++;
    if (late !== 11) begin
      n_err++; $display("FAIL fixed_req1_grant: cycle %0d required 11", late);
    end
    bus.req1 = 1'b0;
    wait_idle();
  endtask
`endif

  task automatic test_busy_request();
    int early = 0, first1 = -1;
    @(negedge clk);
    clear_inputs();
    bus.req0 = 1'b1; bus.pc0 = 26'h0000333; bus.data0 = 32'h33333333;
    bus.pc1 = 26'h0000444; bus.opcode1 = 6'h04; bus.data1 = 32'h44444444;
    for (int i = 1; i <= 25 && first1 < 0; i++) begin
      @(negedge clk);
      if (bus.ack0 === 1'b1) bus.req0 = 1'b0;
      if (bus.ack1 === 1'b1) begin
        first1 = i;
        n_vec++;
        if (bus.o_src !== 1'b1 || bus.o_pc !== 26'h0000444) begin
          n_err++;
          $display("FAIL busy_req_payload: src=%b pc=%h required 1/0000444", bus.o_src, bus.o_pc);
        end
        bus.req1 = 1'b0;
      end
      if (i == 2) bus.req1 = 1'b1;
      if (i >= 2 && i <= 15 && bus.ack1 === 1'b1) early++;
    end
    n_vec++;
    if (early !== 0) begin
      n_err++; $display("FAIL busy_req_early_ack: %0d acks required 0", early);
    end
    n_vec++;
    if (first1 !== 16) begin
      n_err++; $display("FAIL busy_req_latency: cycle %0d required 16", first1);
    end
    bus.req1 = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n_spur = 0;
    @(negedge clk);
    clear_inputs();
    bus.req0 = 1'b1; bus.pc0 = 26'h2ABCDEF; bus.data0 = 32'hCAFEF00D;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (bus.ack0 === 1'b1) bus.req0 = 1'b0;
    end
    n_vec++;
    if (bus.busy !== 1'b1 || bus.o_wlcd !== 1'b0 || bus.o_pc !== 26'h2ABCDEF) begin
      n_err++;
      $display("FAIL mid_pre_dwell: busy=%b wlcd=%b pc=%h required 1/0/2abcdef",
               bus.busy, bus.o_wlcd, bus.o_pc);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.o_pc, bus.o_data, bus.o_src, bus.busy} !== 60'b0) begin
      n_err++;
      $display("FAIL mid_reset_clear: pc=%h data=%h src=%b busy=%b required 0",
               bus.o_pc, bus.o_data, bus.o_src, bus.busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.o_wlcd !== 1'b0 || bus.busy !== 1'b0)
        n_spur++;
    end
    n_vec++;
    if (n_spur !== 0) begin
      n_err++; $display("FAIL mid_reset_spurious: %0d cycles required 0", n_spur);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
`ifdef LCD_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_busy_request();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Shares the single 16x2 LCD display-update port (write strobe plus PC/OPCODE/DATA payload feeding LCD_Display) between two requesters: requester 0 is the CPU output path, requester 1 is the debug/monitor path. A request/acknowledge handshake latches one requester's payload at a time. The block then drives a write strobe of fixed length and holds the payload stable for a dwell interval, so each message stays readable before the next grant. It sits between the CPU/debug logic and the LCD top level, in the 50 MHz domain.

## Interface
- STROBE_CYCLES, 4: cycles o_wlcd is held high per grant; legal range ≥1.
- DWELL_CYCLES, 25_000_000: cycles the payload is held after the strobe (0.5 s at 50 MHz); legal range ≥1.
- iCLK_50MHZ  in  1  system clock; all logic on rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 (CPU) request; level, held until ack0.
- pc0  in  26  requester 0 PC payload.
- opcode0  in  6  requester 0 opcode payload.
- data0  in  32  requester 0 data payload.
- req1, pc1, opcode1, data1  in  1/26/6/32  requester 1 (debug), same meaning.
- ack0  out  1  one-cycle pulse: requester 0 payload latched.
- ack1  out  1  one-cycle pulse: requester 1 payload latched.
- o_wlcd  out  1  LCD write strobe.
- o_pc  out  26  latched PC to LCD.
- o_opcode  out  6  latched opcode to LCD.
- o_data  out  32  latched data to LCD.
- o_src  out  1  source of the current payload (0/1).
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, STROBE, DWELL. A single down-counter is shared by STROBE and DWELL and is sized for the larger of STROBE_CYCLES-1 and DWELL_CYCLES-1.
- IDLE: if any req is high at an edge, pick a winner:
  - ackN pulses for one cycle.
  - Winner's payload goes to o_pc/o_opcode/o_data; o_src gets the winner's index.
  - o_wlcd goes to 1, counter loads STROBE_CYCLES-1, state goes to STROBE.
- STROBE: each edge decrements the counter. At counter==0: o_wlcd goes to 0, counter loads DWELL_CYCLES-1, state goes to DWELL.
- DWELL: each edge decrements the counter. At counter==0: state goes to IDLE.
- Payload outputs are held from the grant edge until the next grant. They are never cleared between messages.
- Arbitration with both requests high is round-robin: the requester not granted last wins. The last-grant register resets to 1, so requester 0 wins the first tie.
- Requests seen outside IDLE are ignored and neither ack pulses. A requester must keep req and payload stable until its ack.
- A req dropped before its ack has no effect. A req still high in the cycle its ack pulses is a new request; the requester must drop req on seeing ack.
- Unknown or invalid states return to IDLE.

## Timing
- Reset (asynchronous assert, synchronous release edge behaviour is normal):
  - State is IDLE, counter is 0, last-grant is 1.
  - ack0, ack1, o_wlcd, o_src and busy are 0; o_pc, o_opcode and o_data are 0.
- Req to ack latency: ack registers on the first edge at which req is sampled high in IDLE, so ack is visible one cycle after req.
- o_wlcd is high for exactly STROBE_CYCLES cycles, starting in the same cycle as ack.
- busy is high for STROBE_CYCLES+DWELL_CYCLES cycles after the grant edge.
- Minimum spacing between grant edges under continuous requests: STROBE_CYCLES+DWELL_CYCLES+1 cycles.
- Reset mid-STROBE or mid-DWELL: the message is aborted immediately, all outputs take reset values, and no ack is reissued.

## Configuration
- LCD_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties and the last-grant register is not implemented. Requester 1 is granted only in IDLE edges where req0 is low.
- LCD_ARB_FIXED_PRIO_EN undefined: round-robin as specified in Operation.

## Test plan
Benches override STROBE_CYCLES=4 and DWELL_CYCLES=10.
- Reset check: with reset held low, drive req0=1 → all outputs 0. After release, the first edge with req0=1 gives ack0=1, o_wlcd=1 and o_pc=pc0.
- Single request: req0 with pc0=26'h0000ABC, opcode0=6'h3F, data0=32'hDEADBEEF.
  - ack0 pulses once, o_wlcd is high for 4 cycles, busy is high for 14 cycles.
  - The payload stays stable until the next grant.
- Simultaneous requests (round-robin): req0 and req1 held high continuously with drop-on-ack → grants alternate 0,1,0,… with grant edges 15 cycles apart. o_src follows the grant.
- Fixed priority: with LCD_ARB_FIXED_PRIO_EN defined, req0 and req1 held high → req1 is never acked. After req0 drops, req1 is acked on the next IDLE edge.
- Request during a busy message: req1 rises in STROBE cycle 2 → no ack1 until DWELL ends. ack1 arrives 1 cycle after IDLE is re-entered.
- Reset mid-message: assert iRST_N=0 in DWELL cycle 5 → o_pc, o_data, o_src and busy go to 0 immediately. After release the state is IDLE and no spurious ack or o_wlcd occurs.
